// File: rtl/ttl_mux_arbiter_pkg.sv
// Shared definitions for the 74153-style mux arbiter.
// Contents: 2-bit state encoding used by ttl_mux_arbiter.
package ttl_mux_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;  // mux disabled
  localparam logic [1:0] ST_SETUP = 2'd1;  // Select driven, mux still disabled
  localparam logic [1:0] ST_GRANT = 2'd2;  // mux enabled

endpackage

// File: rtl/ttl_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_request : per-requester request levels
//   i_last    : index of the most recently served requester
//   o_winner  : first set request searching upward from i_last+1, wrapping
//   o_any     : at least one request is set
module ttl_rr_pick #(
  parameter int WIDTH_IN     = 4,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN)
) (
  input  logic [WIDTH_IN-1:0]     i_request,
  input  logic [WIDTH_SELECT-1:0] i_last,
  output logic [WIDTH_SELECT-1:0] o_winner,
  output logic                    o_any
);

  logic [WIDTH_SELECT-1:0] w_idx;

  // Scan from the farthest candidate down to the nearest so the nearest
  // set bit after i_last is the final assignment.
  always_comb begin
    o_winner = '0;
    o_any    = |i_request;
    w_idx    = '0;
    for (int k = WIDTH_IN; k >= 1; k--) begin
      w_idx = WIDTH_SELECT'((int'(i_last) + k) % WIDTH_IN);
      if (i_request[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/ttl_mux_arbiter.sv
// Round-robin arbiter sharing one dual 4-input mux (common Select,
// per-block Enable_bar) between WIDTH_IN requesters, with break-before-make
// sequencing and an optional hold-time preemption.
// Ports:
//   Clk        : rising-edge clock
//   Reset      : asynchronous active-high reset
//   Request    : per-requester request levels
//   Select     : registered mux select
//   Enable_bar : registered active-low mux enables, all bits identical
//   Grant      : one-hot grant, zero outside GRANT
//   Busy       : state is not IDLE
//   Preempt    : one-cycle pulse when a grant is revoked by hold timeout
module ttl_mux_arbiter
  import ttl_mux_arbiter_pkg::*;
#(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_IN     = 4,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
  parameter int MAX_HOLD     = 0,
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDTH_IN-1:0]     Request,
  output logic [WIDTH_SELECT-1:0] Select,
  output logic [BLOCKS-1:0]       Enable_bar,
  output logic [WIDTH_IN-1:0]     Grant,
  output logic                    Busy,
  output logic                    Preempt
);

  localparam int CNT_W = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

  // Output delays are a board-level timing annotation; the registered RTL
  // outputs carry no delay.
  if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_delay_note
    $warning("ttl_mux_arbiter: DELAY_RISE/DELAY_FALL are not modelled in RTL");
  end

  logic [1:0]              r_state,      w_state_d;
  logic [WIDTH_SELECT-1:0] r_select,     w_select_d;
  logic [BLOCKS-1:0]       r_enable_bar, w_enable_bar_d;
  logic [WIDTH_IN-1:0]     r_grant,      w_grant_d;
  logic                    r_preempt,    w_preempt_d;
  logic [WIDTH_SELECT-1:0] r_last,       w_last_d;
  logic [CNT_W-1:0]        r_hold_cnt,   w_hold_cnt_d;

  logic [WIDTH_SELECT-1:0] w_winner;
  logic                    w_any;
  logic [WIDTH_IN-1:0]     w_sel_onehot;
  logic                    w_req_sel;
  logic                    w_others;
  logic                    w_timeout;

  ttl_rr_pick #(
    .WIDTH_IN     (WIDTH_IN),
    .WIDTH_SELECT (WIDTH_SELECT)
  ) u_pick (
    .i_request (Request),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any     (w_any)
  );

  assign w_sel_onehot = {{(WIDTH_IN-1){1'b0}}, 1'b1} << r_select;
  assign w_req_sel    = Request[r_select];
  assign w_others     = |(Request & ~w_sel_onehot);
  assign w_timeout    = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_d      = r_state;
    w_select_d     = r_select;
    w_enable_bar_d = r_enable_bar;
    w_grant_d      = r_grant;
    w_preempt_d    = 1'b0;
    w_last_d       = r_last;
    w_hold_cnt_d   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        // Select only moves here, while the mux is disabled.
        if (w_any) begin
          w_select_d = w_winner;
          w_state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_req_sel) begin
          w_enable_bar_d = '0;
          w_grant_d      = w_sel_onehot;
          w_hold_cnt_d   = '0;
          w_state_d      = ST_GRANT;
        end else begin
          w_last_d  = r_select;
          w_state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Release takes precedence over timeout, so no Preempt on a release.
        if (!w_req_sel || (w_timeout && w_others)) begin
          w_enable_bar_d = '1;
          w_grant_d      = '0;
          w_last_d       = r_select;
          w_state_d      = ST_IDLE;
          w_preempt_d    = w_req_sel;
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_enable_bar_d = '1;
        w_grant_d      = '0;
        w_state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_select     <= '0;
      r_enable_bar <= '1;
      r_grant      <= '0;
      r_preempt    <= 1'b0;
      r_last       <= WIDTH_SELECT'(WIDTH_IN - 1);
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_select     <= w_select_d;
      r_enable_bar <= w_enable_bar_d;
      r_grant      <= w_grant_d;
      r_preempt    <= w_preempt_d;
      r_last       <= w_last_d;
      r_hold_cnt   <= w_hold_cnt_d;
    end
  end

  assign Select     = r_select;
  assign Enable_bar = r_enable_bar;
  assign Grant      = r_grant;
  assign Busy       = (r_state != ST_IDLE);
  assign Preempt    = r_preempt;

endmodule

// File: tb/tb_ttl_mux_arbiter.sv
// Self-checking bench for ttl_mux_arbiter: directed steps followed by random
// request traffic, all compared against a behavioural arbiter model.
module tb_ttl_mux_arbiter;

  localparam int NREQ = 4;
  localparam int MAXH = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] Request;
  logic [1:0] Select;
  logic [1:0] Enable_bar;
  logic [3:0] Grant;
  logic       Busy;
  logic       Preempt;

  int n_vec  = 0;
  int n_miss = 0;

  ttl_mux_arbiter #(
    .BLOCKS       (2),
    .WIDTH_IN     (NREQ),
    .WIDTH_SELECT (2),
    .MAX_HOLD     (MAXH),
    .DELAY_RISE   (0),
    .DELAY_FALL   (0)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Request    (Request),
    .Select     (Select),
    .Enable_bar (Enable_bar),
    .Grant      (Grant),
    .Busy       (Busy),
    .Preempt    (Preempt)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: who owns the mux, who was served last, how long held.
  typedef enum {MIdle, MSetup, MGrant} mode_t;
  mode_t m_mode;
  int    m_sel;
  int    m_last;
  int    m_hold;
  bit    m_pre;

  task automatic model_reset();
    m_mode = MIdle;
    m_sel  = 0;
    m_last = NREQ - 1;
    m_hold = 0;
    m_pre  = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] req);
    bit found;
    m_pre = 1'b0;
    found = 1'b0;
    case (m_mode)
      MIdle: begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req[(m_last + k) % NREQ]) begin
            m_sel = (m_last + k) % NREQ;
            found = 1'b1;
          end
        end
        if (found) m_mode = MSetup;
      end
      MSetup: begin
        if (req[m_sel]) begin
          m_mode = MGrant;
          m_hold = 0;
        end else begin
          m_last = m_sel;
          m_mode = MIdle;
        end
      end
      default: begin
        if (!req[m_sel]) begin
          m_last = m_sel;
          m_mode = MIdle;
        end else if (m_hold == MAXH - 1 && (req & ~(4'b0001 << m_sel)) != 4'b0000) begin
          m_last = m_sel;
          m_mode = MIdle;
          m_pre  = 1'b1;
        end else if (m_hold < MAXH) begin
          m_hold = m_hold + 1;
        end
      end
    endcase
  endtask

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_grant;
    exp_grant = (m_mode == MGrant) ? (4'b0001 << m_sel) : 4'b0000;
    check_eq({tag, ".select"},  {6'd0, Select},     8'(m_sel));
    check_eq({tag, ".enb"},     {6'd0, Enable_bar}, (m_mode == MGrant) ? 8'h00 : 8'h03);
    check_eq({tag, ".grant"},   {4'd0, Grant},      {4'd0, exp_grant});
    check_eq({tag, ".busy"},    {7'd0, Busy},       {7'd0, m_mode != MIdle});
    check_eq({tag, ".preempt"}, {7'd0, Preempt},    {7'd0, m_pre});
  endtask

  task automatic cycle(input logic [3:0] req, input string tag);
    Request = req;
    @(posedge Clk);
    model_step(req);
    #1;
    check_all(tag);
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [3:0] req;
    Reset   = 1'b0;
    Request = 4'b0000;
    #1;
    // Reset with all requests high, checked before any clock edge.
    Request = 4'b1111;
    Reset   = 1'b1;
    #1;
    model_reset();
    check_eq("por.enb",   {6'd0, Enable_bar}, 8'h03);
    check_eq("por.sel",   {6'd0, Select},     8'h00);
    check_eq("por.grant", {4'd0, Grant},      8'h00);
    check_eq("por.busy",  {7'd0, Busy},       8'h00);
    @(negedge Clk);
    Reset = 1'b0;

    // Basic grant and release for requester 2.
    reset_dut();
    cycle(4'b0100, "b1");
    check_eq("b1.sel", {6'd0, Select}, 8'h02);
    cycle(4'b0100, "b2");
    check_eq("b2.enb",   {6'd0, Enable_bar}, 8'h00);
    check_eq("b2.grant", {4'd0, Grant},      8'h04);
    for (int i = 0; i < 3; i++) cycle(4'b0100, "bh");
    cycle(4'b0000, "b6");
    check_eq("b6.enb",   {6'd0, Enable_bar}, 8'h03);
    check_eq("b6.grant", {4'd0, Grant},      8'h00);
    check_eq("b6.busy",  {7'd0, Busy},       8'h00);

    // Round robin with all requesting; each grantee drops for one cycle.
    reset_dut();
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111, "rr.pick");
      cycle(4'b1111, "rr.grant");
      check_eq("rr.order", {4'd0, Grant}, 8'(4'b0001 << (g % NREQ)));
      cycle(4'b1111, "rr.hold");
      cycle(4'b1111, "rr.hold");
      cycle(4'b1111 & ~(4'b0001 << (g % NREQ)), "rr.rel");
      check_eq("rr.idle", {7'd0, Busy}, 8'h00);
    end

    // Hold-time preemption of requester 0 by requester 2.
    reset_dut();
    cycle(4'b0001, "p.pick");
    cycle(4'b0001, "p.grant");
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0101, "p.hold");
      check_eq("p.nopre", {7'd0, Preempt}, 8'h00);
    end
    cycle(4'b0101, "p.to");
    check_eq("p.enb", {6'd0, Enable_bar}, 8'h03);
    check_eq("p.pre", {7'd0, Preempt},    8'h01);
    cycle(4'b0101, "p.next");
    check_eq("p.pulse", {7'd0, Preempt}, 8'h00);
    cycle(4'b0101, "p.g2");
    check_eq("p.grant2", {4'd0, Grant}, 8'h04);

    // Abort: request withdrawn during SETUP.
    reset_dut();
    cycle(4'b0010, "a.pick");
    cycle(4'b0000, "a.abort");
    check_eq("a.busy",  {7'd0, Busy},       8'h00);
    check_eq("a.enb",   {6'd0, Enable_bar}, 8'h03);
    cycle(4'b0000, "a.idle");
    check_eq("a.grant", {4'd0, Grant}, 8'h00);

    // Reset between edges while granted.
    reset_dut();
    cycle(4'b0010, "m.pick");
    cycle(4'b0010, "m.grant");
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_eq("m.enb",   {6'd0, Enable_bar}, 8'h03);
    check_eq("m.grant", {4'd0, Grant},      8'h00);
    check_eq("m.sel",   {6'd0, Select},     8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    cycle(4'b0001, "m.pick2");
    cycle(4'b0001, "m.grant2");
    check_eq("m.grant0", {4'd0, Grant}, 8'h01);

    // Random traffic: requests toggle slowly so grants run long enough to
    // reach the hold limit; an occasional asynchronous reset is mixed in.
    reset_dut();
    req = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = int'($urandom_range(0, NREQ - 1));
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 149) == 0) begin
        reset_dut();
      end
      cycle(req, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
